// File: rtl/deg_conv_sched_pkg.sv
// Shared widths, scheduler state encoding and result record for the degree-converter scheduler.
// Pure declarations: no logic, no timing.
package deg_pkg;
   localparam int DEG_W = 14;
   localparam int DEC_W = 64;
   localparam int FRC_W = 4;
   localparam int ID_W  = 3;   // wide enough for the largest supported NREQ (8)

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [DEG_W-1:0] deg;
      logic             err;
   } deg_res_t;
endpackage

// File: rtl/deg_conv_sched_rr_arbiter.sv
// Round-robin pick of the first requester at or above ptr, wrapping; purely combinational.
// Zero latency; no backpressure of its own, the caller decides when a grant is taken.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic                    gnt_valid,
   output logic [$clog2(NREQ)-1:0] gnt_id
);
   localparam int IDW = $clog2(NREQ);

   always_comb begin
      logic [IDW:0] idx;
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      // Scan from the farthest offset down so the closest hit to ptr is written last.
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (IDW + 1)'(i);
         if (idx >= (IDW + 1)'(NREQ))
            idx = idx - (IDW + 1)'(NREQ);
         if (req[idx[IDW-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_id    = idx[IDW-1:0];
         end
      end
   end
endmodule

// File: rtl/deg_conv_sched.sv
// Shares one BCD-to-degree converter among NREQ requesters; ack at C+1, start at C+2, result one cycle after finish.
// One job in flight, requesters wait on their level request; DEG_SCHED_TIMEOUT_EN adds a converter watchdog.
module deg_conv_sched
   import deg_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int CV_TIMEOUT = 64
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NREQ-1:0]               i_req,
   input  logic [NREQ-1:0][DEC_W-1:0]    i_decimal,
   input  logic [NREQ-1:0][FRC_W-1:0]    i_frccnt,
   output logic [NREQ-1:0]               o_ack,
   output logic                          o_valid,
   output logic [$clog2(NREQ)-1:0]       o_id,
   output logic [DEG_W-1:0]              o_deg,
   output logic                          o_err,
   output logic                          o_busy,
   output logic                          o_cv_start,
   output logic [DEC_W-1:0]              o_cv_decimal,
   output logic [FRC_W-1:0]              o_cv_frccnt,
   input  logic [DEG_W-1:0]              i_cv_deg,
   input  logic                          i_cv_finished
);
   localparam int IDW = $clog2(NREQ);

   sched_state_e   state_q, state_d;
   logic [IDW-1:0] ptr_q, id_q, gnt_id;
   logic           gnt_valid;
   logic           rej_q;
   logic           to_hit;
   logic           res_ld;
   deg_res_t       res_q, res_d;
   logic           grant;
   logic           unused_id;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req       (i_req),
      .ptr       (ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign grant = (state_q == S_IDLE) && gnt_valid;

`ifdef DEG_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(CV_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         to_cnt_q <= '0;
      else if (state_q == S_ISSUE)
         to_cnt_q <= '0;
      else if (state_q == S_WAIT)
         to_cnt_q <= to_cnt_q + TO_W'(1);
   end

   assign to_hit = (state_q == S_WAIT) && (to_cnt_q == TO_W'(CV_TIMEOUT - 1));
`else
   logic unused_cfg;
   assign to_hit     = 1'b0;
   assign unused_cfg = (CV_TIMEOUT > 0);
`endif

   always_comb begin
      state_d = state_q;
      res_ld  = 1'b0;
      res_d   = res_q;
      case (state_q)
         S_IDLE:
            if (gnt_valid) state_d = S_ISSUE;
         // Rejected jobs still pass through ISSUE so their result lands at C+2; start is suppressed.
         S_ISSUE:
            if (rej_q) begin
               state_d = S_DONE;
               res_ld  = 1'b1;
               res_d   = '{id: ID_W'(id_q), deg: '0, err: 1'b1};
            end else begin
               state_d = S_WAIT;
            end
         S_WAIT:
            if (i_cv_finished) begin
               state_d = S_DONE;
               res_ld  = 1'b1;
               res_d   = '{id: ID_W'(id_q), deg: i_cv_deg, err: 1'b0};
            end else if (to_hit) begin
               state_d = S_DONE;
               res_ld  = 1'b1;
               res_d   = '{id: ID_W'(id_q), deg: '0, err: 1'b1};
            end
         S_DONE:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         id_q         <= '0;
         rej_q        <= 1'b0;
         o_ack        <= '0;
         o_cv_start   <= 1'b0;
         o_cv_decimal <= '0;
         o_cv_frccnt  <= '0;
         res_q        <= '0;
      end else begin
         state_q    <= state_d;
         o_ack      <= '0;
         o_cv_start <= (state_q == S_ISSUE) && !rej_q;
         if (grant) begin
            o_ack        <= NREQ'(1) << gnt_id;
            id_q         <= gnt_id;
            ptr_q        <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            o_cv_decimal <= i_decimal[gnt_id];
            o_cv_frccnt  <= i_frccnt[gnt_id];
            rej_q        <= (i_frccnt[gnt_id] == '0);
         end
         if (res_ld)
            res_q <= res_d;
      end
   end

   assign o_valid   = (state_q == S_DONE);
   assign o_busy    = (state_q != S_IDLE);
   assign o_id      = res_q.id[IDW-1:0];
   assign o_deg     = res_q.deg;
   assign o_err     = res_q.err;
   assign unused_id = ^res_q.id;
endmodule
